// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sorter datapath: sample width, frame size
// and the loader/unloader state encoding.
package sort_pkg;

    localparam int SORT_W = 2;
    localparam int SORT_N = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } loader_state_t;

endpackage

// File: rtl/sort_loader.sv
// Upstream feeder for the 4-entry sorter: gathers samples into a frame, presents
// it atomically, then holds it for a settle window before taking the next frame.
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | in_ready=1, samples land in shadow slots; 4th sample loads o1..o4
// HOLD    | in_ready=0, frame held for SETTLE cycles; exit pulses sort_done
module sort_loader
    import sort_pkg::*;
#(
    parameter int W      = SORT_W,
    parameter int SETTLE = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic [W-1:0] o3,
    output logic [W-1:0] o4,
    output logic         frame_valid,
    output logic         sort_done
);

    localparam int HW = $clog2(SETTLE + 1);

    loader_state_t state, state_nx;
    logic [1:0]    cnt, cnt_nx;
    logic [HW-1:0] hold_cnt, hold_cnt_nx;
    // Only three shadow slots: the 4th sample goes straight to o4 on the load edge.
    logic [SORT_N-2:0][W-1:0] shadow, shadow_nx;
    logic          accept;
    logic          load;
    logic          settle_end;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        hold_cnt_nx = hold_cnt;
        shadow_nx   = shadow;
        in_ready    = (state == COLLECT);
        accept      = in_valid && in_ready;
        load        = 1'b0;
        settle_end  = 1'b0;

        case (state)
            COLLECT: begin
                if (accept) begin
                    if (cnt == 2'd3) begin
                        load        = 1'b1;
                        cnt_nx      = 2'd0;
                        hold_cnt_nx = '0;
                        state_nx    = HOLD;
                    end else begin
                        shadow_nx[cnt] = in_data;
                        cnt_nx         = cnt + 2'd1;
                    end
                end
            end
            HOLD: begin
                hold_cnt_nx = hold_cnt + HW'(1);
                if (hold_cnt == HW'(SETTLE - 1)) begin
                    hold_cnt_nx = '0;
                    settle_end  = 1'b1;
                    state_nx    = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            cnt         <= 2'd0;
            hold_cnt    <= '0;
            shadow      <= '0;
            o1          <= '0;
            o2          <= '0;
            o3          <= '0;
            o4          <= '0;
            frame_valid <= 1'b0;
            sort_done   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            hold_cnt  <= hold_cnt_nx;
            shadow    <= shadow_nx;
            sort_done <= settle_end;
            if (load) begin
                o1          <= shadow[0];
                o2          <= shadow[1];
                o3          <= shadow[2];
                o4          <= in_data;
                frame_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sort_loader.sv
// Scoreboard bench for sort_loader: expected frames are queued by the stimulus
// and checked by a monitor whenever the presented frame changes.
module tb_sort_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] o1, o2, o3, o4;
    logic       frame_valid;
    logic       sort_done;

    logic [1:0] in_data_s1 = '0;
    logic       in_valid_s1 = 1'b0;
    logic       in_ready_s1;
    logic [1:0] o1_s1, o2_s1, o3_s1, o4_s1;
    logic       frame_valid_s1;
    logic       sort_done_s1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [8:0] last = '0;

    sort_loader #(.W(2), .SETTLE(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .o1(o1), .o2(o2), .o3(o3), .o4(o4),
        .frame_valid(frame_valid), .sort_done(sort_done)
    );

    sort_loader #(.W(2), .SETTLE(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_s1), .in_valid(in_valid_s1),
        .in_ready(in_ready_s1), .o1(o1_s1), .o2(o2_s1), .o3(o3_s1), .o4(o4_s1),
        .frame_valid(frame_valid_s1), .sort_done(sort_done_s1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: any change of the presented frame must match the next queued frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            last = '0;
        end else if ({o1, o2, o3, o4, frame_valid} !== last) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame_change", {23'd0, o1, o2, o3, o4, frame_valid}, {23'd0, last});
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("frame", {24'd0, o1, o2, o3, o4}, {24'd0, e});
                chk("frame_valid", {31'd0, frame_valid}, 32'd1);
            end
            last = {o1, o2, o3, o4, frame_valid};
        end
    end

    // Waits for in_ready (bounded), then lets the next edge accept v.
    task automatic send(input logic [1:0] v);
        logic r;
        logic done;
        int n;
        in_valid = 1'b1;
        in_data  = v;
        done = 1'b0;
        n = 0;
        while (!done) begin
            r = in_ready;
            @(posedge clk); #1;
            if (r) done = 1'b1;
            else begin
                n++;
                if (n > 50) begin
                    chk("send_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sort_done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_sort_done", {31'd0, sort_done}, 32'd1);
    endtask

    initial begin
        int lows;
        int t_a, t_b;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {23'd0, o1, o2, o3, o4, frame_valid}, 32'd0);
        chk("reset_sort_done", {31'd0, sort_done}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // SETTLE=1 instance: one HOLD cycle, sort_done on the following edge.
        in_valid_s1 = 1'b1;
        in_data_s1 = 2'd1; @(posedge clk); #1;
        in_data_s1 = 2'd3; @(posedge clk); #1;
        in_data_s1 = 2'd2; @(posedge clk); #1;
        in_data_s1 = 2'd0; @(posedge clk); #1;
        in_valid_s1 = 1'b0;
        chk("s1_frame", {24'd0, o1_s1, o2_s1, o3_s1, o4_s1}, 32'h78);
        chk("s1_frame_valid", {31'd0, frame_valid_s1}, 32'd1);
        chk("s1_hold_ready", {31'd0, in_ready_s1}, 32'd0);
        chk("s1_hold_done", {31'd0, sort_done_s1}, 32'd0);
        @(posedge clk); #1;
        chk("s1_done_ready", {31'd0, in_ready_s1}, 32'd1);
        chk("s1_done_pulse", {31'd0, sort_done_s1}, 32'd1);
        @(posedge clk); #1;
        chk("s1_done_clear", {31'd0, sort_done_s1}, 32'd0);

        // Basic frame 3,2,0,1
        exp_q.push_back(8'b11_10_00_01);
        send(2'd3); send(2'd2); send(2'd0); send(2'd1);
        in_valid = 1'b0;
        chk("basic_frame", {24'd0, o1, o2, o3, o4}, 32'hE1);
        lows = 0;
        while (in_ready === 1'b0 && lows < 30) begin
            lows++;
            @(posedge clk); #1;
        end
        chk("basic_hold_cycles", lows, 32'd6);
        chk("basic_done_pulse", {31'd0, sort_done}, 32'd1);
        chk("basic_done_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("basic_done_clear", {31'd0, sort_done}, 32'd0);

        // Gapped input 1, gap, 2, gap x3, 3, 0; previous frame must stay visible
        send(2'd1); idle(1);
        send(2'd2); idle(3);
        send(2'd3);
        chk("gapped_hold_prev", {24'd0, o1, o2, o3, o4}, 32'hE1);
        exp_q.push_back(8'b01_10_11_00);
        send(2'd0);
        in_valid = 1'b0;
        wait_done();

        // Backpressure: valid held high with 2 through HOLD
        exp_q.push_back(8'b00_11_01_10);
        send(2'd0); send(2'd3); send(2'd1); send(2'd2);
        lows = 0;
        while (in_ready === 1'b0 && lows < 30) begin
            lows++;
            @(posedge clk); #1;
        end
        chk("bp_hold_cycles", lows, 32'd6);
        chk("bp_done_with_ready", {31'd0, sort_done}, 32'd1);
        exp_q.push_back(8'b10_01_01_00);
        send(2'd2);
        send(2'd1); send(2'd1); send(2'd0);

        // Back-to-back frames A=0,1,2,3 and B=3,3,1,1, valid held throughout
        exp_q.push_back(8'b00_01_10_11);
        send(2'd0); send(2'd1); send(2'd2); send(2'd3);
        t_a = cyc;
        exp_q.push_back(8'b11_11_01_01);
        send(2'd3); send(2'd3); send(2'd1);
        chk("b2b_a_still_shown", {24'd0, o1, o2, o3, o4}, 32'h1B);
        send(2'd1);
        t_b = cyc;
        chk("b2b_period", t_b - t_a, 32'd10);

        // Reset mid-frame: two samples of the next frame, then async reset
        send(2'd1); send(2'd2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {23'd0, o1, o2, o3, o4, frame_valid}, 32'd0);
        chk("async_reset_done", {31'd0, sort_done}, 32'd0);
        chk("async_reset_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(8'b10_00_11_01);
        send(2'd2); send(2'd0); send(2'd3); send(2'd1);
        in_valid = 1'b0;
        chk("post_reset_frame", {24'd0, o1, o2, o3, o4}, 32'h8D);
        wait_done();
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
